// File: rtl/fsub_pipe.sv
// Three-stage pipelined IEEE-754 binary32 subtractor (y = x1 - x2), round-to-nearest-even,
// gradual underflow, valid/ready handshake on both sides with a global stall on output backpressure.
module fsub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);
  localparam int STAGES = 3;

  logic [STAGES:1] vld_q;
  logic            stall, en;

  assign stall     = vld_q[STAGES] & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];

  // ---------------- S1: unpack, classify, order by magnitude, align ----------------
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  ea, eb, big_e, sml_e, dexp;
  logic [23:0] ma, mb, big_m, sml_m;
  logic [4:0]  dsh;
  logic [57:0] wide;
  logic        s1_sp_d, s1_sign_d, s1_sub_d, s1_zs_d;
  logic [31:0] s1_spv_d;
  logic [7:0]  s1_e_d;
  logic [26:0] s1_ma_d, s1_mb_d;
  logic        s1_sp_q, s1_sign_q, s1_sub_q, s1_zs_q;
  logic [31:0] s1_spv_q;
  logic [7:0]  s1_e_q;
  logic [26:0] s1_ma_q, s1_mb_q;

  always_comb begin
    a_nan = (&x1[30:23]) & (|x1[22:0]);
    b_nan = (&x2[30:23]) & (|x2[22:0]);
    a_inf = (&x1[30:23]) & ~(|x1[22:0]);
    b_inf = (&x2[30:23]) & ~(|x2[22:0]);
    s1_sp_d = (&x1[30:23]) | (&x2[30:23]);
    if (b_nan)              s1_spv_d = {x2[31], 8'hFF, 1'b1, x2[21:0]};
    else if (a_nan)         s1_spv_d = {x1[31], 8'hFF, 1'b1, x1[21:0]};
    else if (a_inf & b_inf) s1_spv_d = (x1[31] != x2[31]) ? x1 : 32'hFFC0_0000;
    else if (a_inf)         s1_spv_d = x1;
    else                    s1_spv_d = {~x2[31], x2[30:0]};

    // Exponent 0 behaves as exponent 1 with no hidden bit.
    ea = (x1[30:23] == 8'd0) ? 8'd1 : x1[30:23];
    eb = (x2[30:23] == 8'd0) ? 8'd1 : x2[30:23];
    ma = {|x1[30:23], x1[22:0]};
    mb = {|x2[30:23], x2[22:0]};
    swap  = x2[30:0] > x1[30:0];
    big_e = swap ? eb : ea;
    sml_e = swap ? ea : eb;
    big_m = swap ? mb : ma;
    sml_m = swap ? ma : mb;
    s1_sign_d = swap ? ~x2[31] : x1[31];
    s1_sub_d  = ~(x1[31] ^ x2[31]);
    s1_zs_d   = x1[31] & ~x2[31];
    dexp = big_e - sml_e;
    dsh  = (dexp > 8'd31) ? 5'd31 : dexp[4:0];
    // Bits shifted past the round position collapse into the sticky LSB.
    wide = {sml_m, 34'd0} >> dsh;
    s1_e_d  = big_e;
    s1_ma_d = {big_m, 3'b000};
    s1_mb_d = {wide[57:32], wide[31] | (|wide[30:0])};
  end

  // ---------------- S2: add/subtract, normalize ----------------
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [7:0]  lim, sh;
  logic [26:0] nrm;
  logic        s2_zero_d;
  logic [8:0]  s2_e_d;
  logic        s2_sp_q, s2_sign_q, s2_zero_q, s2_zs_q;
  logic [31:0] s2_spv_q;
  logic [8:0]  s2_e_q;
  logic [25:0] s2_m_q;

  always_comb begin
    sum = s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q}) : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    lim = s1_e_q - 8'd1;
    sh  = ({3'b000, lz} < lim) ? {3'b000, lz} : lim;
    s2_zero_d = (sum == 28'd0);
    if (sum[27]) begin
      nrm    = {sum[27:2], sum[1] | sum[0]};
      s2_e_d = {1'b0, s1_e_q} + 9'd1;
    end else begin
      // Left shift is capped so the exponent never drops below 1; a missing hidden bit means denormal.
      nrm    = sum[26:0] << sh;
      s2_e_d = nrm[26] ? {1'b0, s1_e_q - sh} : 9'd0;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic        rnd_up, big;
  logic [30:0] packed_mag;
  logic [31:0] y_d;
  logic        ovf_d;
  logic [31:0] y_q;
  logic        ovf_q;

  always_comb begin
    rnd_up     = s2_m_q[2] & (s2_m_q[1] | s2_m_q[0] | s2_m_q[3]);
    packed_mag = {s2_e_q[7:0], s2_m_q[25:3]} + {30'd0, rnd_up};
    big        = (s2_e_q >= 9'd255) | (&packed_mag[30:23]);
    ovf_d      = 1'b0;
    if (s2_sp_q)        y_d = s2_spv_q;
    else if (s2_zero_q) y_d = {s2_zs_q, 31'd0};
    else if (big) begin
      y_d   = {s2_sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else            y_d = {s2_sign_q, packed_mag};
  end

  assign y   = y_q;
  assign ovf = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      s1_sp_q  <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_zs_q <= 1'b0;
      s1_spv_q <= '0;   s1_e_q    <= '0;   s1_ma_q  <= '0;   s1_mb_q <= '0;
      s2_sp_q  <= 1'b0; s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_zs_q <= 1'b0;
      s2_spv_q <= '0;   s2_e_q    <= '0;   s2_m_q    <= '0;
      y_q      <= '0;   ovf_q     <= 1'b0;
    end else if (en) begin
      vld_q    <= {vld_q[STAGES-1:1], in_valid};
      s1_sp_q  <= s1_sp_d;  s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d; s1_zs_q <= s1_zs_d;
      s1_spv_q <= s1_spv_d; s1_e_q    <= s1_e_d;    s1_ma_q  <= s1_ma_d;  s1_mb_q <= s1_mb_d;
      s2_sp_q  <= s1_sp_q;  s2_sign_q <= s1_sign_q; s2_zero_q <= s2_zero_d; s2_zs_q <= s1_zs_q;
      s2_spv_q <= s1_spv_q; s2_e_q    <= s2_e_d;    s2_m_q    <= nrm[25:0];
      // Bubbles leave the last delivered result on y/ovf.
      if (vld_q[2]) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end
endmodule
